// File: rtl/hex_entry_display.sv
// Calculator-style hex entry register with active-low 7-segment drive.
// Optional blink of a full register: define HEX_ENTRY_DISPLAY_BLINK_EN.
module hex_entry_display #(
  parameter int NDIGITS   = 4,
  parameter int OVF_DROP  = 1,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [3:0]             digit_in,
  input  logic                   push,
  input  logic                   bksp,
  input  logic                   clr,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_val,
  output logic [4*NDIGITS-1:0]   value,
  output logic [3:0]             count,
  output logic                   full,
  output logic                   ovf,
  output logic [7*NDIGITS-1:0]   HEX
);

  localparam int W = 4 * NDIGITS;

  logic [W-1:0] value_q, value_d;
  logic [3:0]   count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         full_w;
  logic         blink_off;

  assign full_w = (count_q == 4'(NDIGITS));

  // Next-state for the entry register; one command wins per cycle.
  always_comb begin
    value_d = value_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clr) begin
      value_d = '0;
      count_d = 4'd0;
    end else if (load) begin
      value_d = load_val;
      count_d = 4'(NDIGITS);
    end else if (push) begin
      if (!full_w) begin
        value_d = (value_q << 4) | W'(digit_in);
        count_d = count_q + 4'd1;
      end else begin
        ovf_d = 1'b1;
        if (OVF_DROP != 0) begin
          value_d = (value_q << 4) | W'(digit_in);
        end
      end
    end else if (bksp) begin
      if (count_q != 4'd0) begin
        value_d = value_q >> 4;
        count_d = count_q - 4'd1;
      end
    end
  end

  // Register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef HEX_ENTRY_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] bcnt_q;
  logic          phase_q;
  logic          cmd;

  assign cmd = clr | load | push | bksp;

  // Blink timebase; any command restarts it in the on phase.
  always_ff @(posedge clk) begin
    if (rst || cmd) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      bcnt_q  <= bcnt_q + 1'b1;
    end
  end

  assign blink_off = full_w & ~phase_q;
`else
  // No blink hardware: the display is always steady.
  assign blink_off = (BLINK_DIV < 0);
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Segment drive: only entered digits lit; empty register shows "0".
  always_comb begin
    logic lit;
    HEX = '1;
    lit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      lit = en && !blink_off &&
            ((4'(i) < count_q) || (i == 0 && count_q == 4'd0));
      HEX[7*i +: 7] = lit ? seg7(value_q[4*i +: 4]) : 7'h7F;
    end
  end

  assign value = value_q;
  assign count = count_q;
  assign full  = full_w;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_hex_entry_display.sv
// Directed bench for hex_entry_display, NDIGITS=4.
// dut drops the MSD on overflow, dut0 rejects the push.
module tb_hex_entry_display;

  logic        clk = 1'b0;
  logic        rst, en, push, bksp, clr, load;
  logic [3:0]  digit_in;
  logic [15:0] load_val;

  logic [15:0] value, value0;
  logic [3:0]  count, count0;
  logic        full, full0, ovf, ovf0;
  logic [27:0] HEX, HEX0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hex_entry_display #(.NDIGITS(4), .OVF_DROP(1), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .digit_in(digit_in),
    .push(push), .bksp(bksp), .clr(clr), .load(load),
    .load_val(load_val), .value(value), .count(count),
    .full(full), .ovf(ovf), .HEX(HEX)
  );

  hex_entry_display #(.NDIGITS(4), .OVF_DROP(0), .BLINK_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .digit_in(digit_in),
    .push(push), .bksp(bksp), .clr(clr), .load(load),
    .load_val(load_val), .value(value0), .count(count0),
    .full(full0), .ovf(ovf0), .HEX(HEX0)
  );

  typedef struct {
    logic        c, l, p, b, e;
    logic [3:0]  d;
    logic [15:0] lv;
    logic [15:0] xv;
    logic [3:0]  xc;
    logic        xo;
    logic [27:0] xh;
    logic [15:0] xv0;
    logic        xo0;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [27:0] ALLB = {BL, BL, BL, BL};

  vec_t v[23];

  initial begin
    v[0]  = '{0,0,1,0,1,4'h1,16'h0,16'h0001,1,0,{BL,BL,BL,7'h79},16'h0001,0};
    v[1]  = '{0,0,1,0,1,4'hA,16'h0,16'h001A,2,0,{BL,BL,7'h79,7'h08},16'h001A,0};
    v[2]  = '{0,0,1,0,1,4'h3,16'h0,16'h01A3,3,0,{BL,7'h79,7'h08,7'h30},16'h01A3,0};
    v[3]  = '{1,0,0,0,1,4'h0,16'h0,16'h0000,0,0,{BL,BL,BL,7'h40},16'h0000,0};
    v[4]  = '{0,0,1,0,1,4'h1,16'h0,16'h0001,1,0,{BL,BL,BL,7'h79},16'h0001,0};
    v[5]  = '{0,0,1,0,1,4'h2,16'h0,16'h0012,2,0,{BL,BL,7'h79,7'h24},16'h0012,0};
    v[6]  = '{0,0,1,0,1,4'h3,16'h0,16'h0123,3,0,{BL,7'h79,7'h24,7'h30},16'h0123,0};
    v[7]  = '{0,0,1,0,1,4'h4,16'h0,16'h1234,4,0,{7'h79,7'h24,7'h30,7'h19},16'h1234,0};
    v[8]  = '{0,0,1,0,1,4'h5,16'h0,16'h2345,4,1,{7'h24,7'h30,7'h19,7'h12},16'h1234,1};
    v[9]  = '{0,0,0,0,1,4'h0,16'h0,16'h2345,4,0,{7'h24,7'h30,7'h19,7'h12},16'h1234,0};
    v[10] = '{1,0,0,0,1,4'h0,16'h0,16'h0000,0,0,{BL,BL,BL,7'h40},16'h0000,0};
    v[11] = '{0,0,1,0,1,4'hF,16'h0,16'h000F,1,0,{BL,BL,BL,7'h0E},16'h000F,0};
    v[12] = '{0,0,1,0,1,4'hE,16'h0,16'h00FE,2,0,{BL,BL,7'h0E,7'h06},16'h00FE,0};
    v[13] = '{0,0,0,1,1,4'h0,16'h0,16'h000F,1,0,{BL,BL,BL,7'h0E},16'h000F,0};
    v[14] = '{0,0,0,1,1,4'h0,16'h0,16'h0000,0,0,{BL,BL,BL,7'h40},16'h0000,0};
    v[15] = '{0,0,0,1,1,4'h0,16'h0,16'h0000,0,0,{BL,BL,BL,7'h40},16'h0000,0};
    v[16] = '{1,1,1,0,1,4'h7,16'hBEEF,16'h0000,0,0,{BL,BL,BL,7'h40},16'h0000,0};
    v[17] = '{0,1,1,0,1,4'h7,16'hBEEF,16'hBEEF,4,0,{7'h03,7'h06,7'h06,7'h0E},16'hBEEF,0};
    v[18] = '{0,0,0,0,0,4'h0,16'h0,16'hBEEF,4,0,ALLB,16'hBEEF,0};
    v[19] = '{0,1,0,1,1,4'h0,16'h1234,16'h1234,4,0,{7'h79,7'h24,7'h30,7'h19},16'h1234,0};
    v[20] = '{0,0,0,1,1,4'h0,16'h0,16'h0123,3,0,{BL,7'h79,7'h24,7'h30},16'h0123,0};
    v[21] = '{0,0,1,1,1,4'h9,16'h0,16'h1239,4,0,{7'h79,7'h24,7'h30,7'h10},16'h1239,0};
    v[22] = '{0,0,1,0,1,4'hA,16'h0,16'h239A,4,1,{7'h24,7'h30,7'h10,7'h08},16'h1239,1};

    rst = 1'b1; en = 1'b1; push = 0; bksp = 0; clr = 0; load = 0;
    digit_in = 4'h0; load_val = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_hex", 32'(HEX), 32'({BL, BL, BL, 7'h40}));

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      clr = v[i].c; load = v[i].l; push = v[i].p; bksp = v[i].b;
      en = v[i].e; digit_in = v[i].d; load_val = v[i].lv;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_value", i), 32'(value), 32'(v[i].xv));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(v[i].xc));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(v[i].xc == 4'd4));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(v[i].xo));
      chk($sformatf("v%0d_hex", i), 32'(HEX), 32'(v[i].xh));
      chk($sformatf("v%0d_value0", i), 32'(value0), 32'(v[i].xv0));
      chk($sformatf("v%0d_ovf0", i), 32'(ovf0), 32'(v[i].xo0));
    end

    // Full register left idle: blinks when the feature is built in.
    @(negedge clk);
    clr = 0; load = 0; push = 0; bksp = 0; en = 1;
    for (int k = 1; k <= 12; k++) begin
      logic [27:0] exp_h;
      @(posedge clk);
      #1;
      exp_h = {7'h24, 7'h30, 7'h10, 7'h08};
`ifdef HEX_ENTRY_DISPLAY_BLINK_EN
      if (((k / 4) % 2) == 1) exp_h = ALLB;
`endif
      chk($sformatf("blink_k%0d", k), 32'(HEX), 32'(exp_h));
      chk($sformatf("blink_val_k%0d", k), 32'(value), 32'h239A);
    end

    // Backspace out of full: steady display afterwards.
    @(negedge clk);
    bksp = 1;
    @(posedge clk);
    #1;
    chk("bk_value", 32'(value), 32'h0239);
    chk("bk_count", 32'(count), 32'd3);
    @(negedge clk);
    bksp = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("steady_k%0d", k), 32'(HEX),
          32'({BL, 7'h24, 7'h30, 7'h10}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
